right_shifter_seq: RTL and testbench

Iterative 64-bit right shifter, the counterpart of the fixed 8-bit left shifter in the datapath. It performs a logical or arithmetic right shift by 0–63 positions using only two hardwired shift stages: 8 positions per step and 1 position per step. A start/done handshake lets the ALU sequencer issue one operation at a time and collect the registered result.

---
 rtl/right_shifter_seq_if.sv | 22 ++
 rtl/right_shifter_seq.sv | 85 ++++++++
 tb/tb_right_shifter_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/right_shifter_seq_if.sv
// Request/response bundle for the iterative 64-bit right shifter.
// The sequencer drives the request side; the shifter answers with status and result.
interface right_shifter_seq_if;
  logic        start;
  logic [63:0] a;
  logic [5:0]  shamt;
  logic        arith;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] result;

  modport master (
    output start, a, shamt, arith,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, a, shamt, arith,
    output ready, busy, done, result
  );
endinterface

// File: rtl/right_shifter_seq.sv
// Iterative 64-bit logical/arithmetic right shifter built from two fixed stages
// (8 and 1 positions per step); start/done handshake, one operation at a time.
//
// state   | meaning
// IDLE    | waiting for start; ready=1
// SHIFT   | one 8- or 1-position step per cycle; busy=1
// DONE    | result valid, done pulse; ready=1, may accept back-to-back
module right_shifter_seq (
  input  logic                 i_clock,
  input  logic                 i_reset,
  right_shifter_seq_if.slave   s_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_acc;
  logic [5:0]  r_rem;
  logic        r_fill;

  state_t      w_state_nxt;
  logic [63:0] w_acc_nxt;
  logic [5:0]  w_rem_nxt;
  logic        w_fill_nxt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_fill_nxt  = r_fill;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (s_bus.start) begin
          w_acc_nxt   = s_bus.a;
          w_rem_nxt   = s_bus.shamt;
          w_fill_nxt  = s_bus.arith & s_bus.a[63];
          w_state_nxt = (s_bus.shamt == 6'd0) ? S_DONE : S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_SHIFT: begin
        // Coarse steps first, then single-bit steps for the low three bits.
        if (r_rem >= 6'd8) begin
          w_acc_nxt = {{8{r_fill}}, r_acc[63:8]};
          w_rem_nxt = r_rem - 6'd8;
        end else begin
          w_acc_nxt = {r_fill, r_acc[63:1]};
          w_rem_nxt = r_rem - 6'd1;
        end
        w_state_nxt = (w_rem_nxt == 6'd0) ? S_DONE : S_SHIFT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign s_bus.ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign s_bus.busy   = (r_state == S_SHIFT);
  assign s_bus.done   = (r_state == S_DONE);
  assign s_bus.result = r_acc;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Self-checking bench for right_shifter_seq: directed scenarios plus random
// operations compared against a plain-arithmetic shift model.
module tb_right_shifter_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  right_shifter_seq_if bus ();

  right_shifter_seq dut (
    .i_clock (clk),
    .i_reset (rst),
    .s_bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_shift(input logic [63:0] a, input int sh, input bit ar);
    logic signed [63:0] sa;
    logic [63:0] r;
    sa = a;
    if (ar) begin
      sa = sa >>> sh;
      r  = sa;
    end else begin
      r = a >> sh;
    end
    return r;
  endfunction

  function automatic int model_steps(input int sh);
    return sh / 8 + sh % 8;
  endfunction

  // Issues one request and reports latency (cycles to done), busy cycles and result.
  task automatic run_op(input logic [63:0] a, input logic [5:0] sh, input bit ar,
                        output int lat, output int busy_cnt, output logic [63:0] res);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.shamt = sh;
    bus.arith = ar;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = {$urandom, $urandom};
    bus.shamt = 6'($urandom);
    bus.arith = 1'($urandom);
    lat      = -1;
    busy_cnt = 0;
    res      = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = c;
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_checks++; if (bus.result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_arith_one_step();
    int lat, bc;
    logic [63:0] res;
    run_op(64'h8000_0000_0000_0000, 6'd8, 1'b1, lat, bc, res);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL one_step_latency got %0d exp 2", lat); end
    n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL one_step_busy got %0d exp 1", bc); end
    n_checks++; if (res !== 64'hFF80_0000_0000_0000) begin n_fail++; $display("FAIL one_step_result got %h exp ff80000000000000", res); end
  endtask

  task automatic test_max_shift();
    int lat, bc;
    logic [63:0] res;
    run_op(64'h8000_0000_0000_0000, 6'd63, 1'b0, lat, bc, res);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL max_log_latency got %0d exp 15", lat); end
    n_checks++; if (bc !== 14) begin n_fail++; $display("FAIL max_log_busy got %0d exp 14", bc); end
    n_checks++; if (res !== 64'h1) begin n_fail++; $display("FAIL max_log_result got %h exp 1", res); end
    run_op(64'h8000_0000_0000_0000, 6'd63, 1'b1, lat, bc, res);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL max_ari_latency got %0d exp 15", lat); end
    n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL max_ari_result got %h exp ffffffffffffffff", res); end
  endtask

  task automatic test_zero_shift();
    int lat, bc;
    logic [63:0] res;
    run_op(64'h0123_4567_89AB_CDEF, 6'd0, 1'b1, lat, bc, res);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency got %0d exp 1", lat); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL zero_busy got %0d exp 0", bc); end
    n_checks++; if (res !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL zero_result got %h exp 0123456789abcdef", res); end
  endtask

  task automatic test_start_while_busy();
    int extra_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.shamt = 6'd12;
    bus.arith = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      #1;
      bus.start = 1'b1;
      bus.a     = {$urandom, $urandom};
      bus.shamt = 6'($urandom_range(1, 63));
      bus.arith = 1'($urandom);
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL swb_cycle%0d busy=%b done=%b exp busy=1 done=0", c, bus.busy, bus.done); end
      @(posedge clk);
    end
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL swb_done got %b exp 1 in cycle 6", bus.done); end
    n_checks++; if (bus.result !== 64'h000F_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL swb_result got %h exp 000fffffffffffff", bus.result); end
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    n_checks++; if (extra_done !== 0) begin n_fail++; $display("FAIL swb_second_done got %0d extra pulses exp 0", extra_done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [63:0] res;
    bit seen;
    run_op(64'hDEAD_BEEF_0000_1234, 6'd5, 1'b0, lat, bc, res);
    n_checks++; if (res !== model_shift(64'hDEAD_BEEF_0000_1234, 5, 1'b0)) begin n_fail++; $display("FAIL b2b_first_result got %h exp %h", res, model_shift(64'hDEAD_BEEF_0000_1234, 5, 1'b0)); end
    // Still in the DONE cycle of the first operation: issue the second now.
    bus.start = 1'b1;
    bus.a     = 64'hF0;
    bus.shamt = 6'd3;
    bus.arith = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_cycle%0d got %b exp 1", c, bus.busy); end
    end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b exp 1", bus.done); end
    n_checks++; if (bus.result !== 64'h1E) begin n_fail++; $display("FAIL b2b_result got %h exp 1e", bus.result); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, stray;
    logic [63:0] res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 64'hA5A5_5A5A_1234_5678;
    bus.shamt = 6'd40;
    bus.arith = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", bus.ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b exp 0", bus.done); end
    n_checks++; if (bus.result !== 64'd0) begin n_fail++; $display("FAIL rmid_result got %h exp 0", bus.result); end
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_stray_done got %0d exp 0", stray); end
    run_op(64'h8000_0000_0000_00FF, 6'd9, 1'b1, lat, bc, res);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rmid_fresh_latency got %0d exp 3", lat); end
    n_checks++; if (res !== 64'hFFC0_0000_0000_0000) begin n_fail++; $display("FAIL rmid_fresh_result got %h exp ffc0000000000000", res); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [63:0] a, res, exp_res;
    logic [5:0] sh;
    bit ar;
    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      sh = 6'($urandom);
      ar = 1'($urandom);
      run_op(a, sh, ar, lat, bc, res);
      exp_res = model_shift(a, int'(sh), ar);
      n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL rand%0d_result a=%h sh=%0d ar=%0d got %h exp %h", i, a, sh, ar, res, exp_res); end
      n_checks++; if (lat !== model_steps(int'(sh)) + 1) begin n_fail++; $display("FAIL rand%0d_latency sh=%0d got %0d exp %0d", i, sh, lat, model_steps(int'(sh)) + 1); end
      n_checks++; if (bc !== model_steps(int'(sh))) begin n_fail++; $display("FAIL rand%0d_busy sh=%0d got %0d exp %0d", i, sh, bc, model_steps(int'(sh))); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.shamt = '0;
    bus.arith = 1'b0;
    test_reset();
    test_arith_one_step();
    test_max_shift();
    test_zero_shift();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
